apb_fsm_controller: RTL
=======================

# apb_fsm_controller

APB-side sequencer of the AHB-to-APB bridge, directly downstream of the AHB slave interface stage. Consumes that stage's `valid`, write flag and pipelined address/data registers, and runs APB setup/access phases for up to three peripherals. Drives `h_readyout` back to the AHB slave stage to stall the AHB pipeline while an APB access is in flight.

## Interface
- No parameters; widths fixed at 32-bit address/data, 3 peripheral selects.
- `h_clk` in 1: bridge clock.
- `h_reset` in 1: asynchronous, active-low reset.
- `valid` in 1: qualified NONSEQ/SEQ transfer in AHB address phase.
- `writereg` in 1: write flag of the transfer flagged by `valid`.
- `h_addr` in 32: current AHB address.
- `h_addr1` in 32: address registered by slave stage (updates when `h_readyout`=1).
- `h_wdata` in 32: current AHB write data.
- `p_rdata` in 32: APB read data.
- `p_ready` in 1: APB ready (only with `APB_PREADY_EN`).
- `h_readyout` out 1: AHB ready back to slave stage/master.
- `h_rdata` out 32: read data to AHB, equals `p_rdata`.
- `h_resp` out 2: constant 2'b00 (OKAY).
- `p_sel` out 3: one-hot peripheral select.
- `p_enable` out 1: APB access phase.
- `p_write` out 1: APB direction.
- `p_addr` out 32: APB address.
- `p_wdata` out 32: APB write data.

## Operation
- States: `IDLE`, `READ` (setup), `RENABLE`, `WWAIT`, `WRITE` (setup), `WENABLE`.
- Issue states = `IDLE`, `RENABLE`, and `WENABLE` with `pend`=0. From an issue state: `valid`&!`writereg` → `READ`, `p_addr<=h_addr`; `valid`&`writereg` → `WWAIT`; else → `IDLE`.
- `WWAIT` → `WRITE` unconditionally. `p_addr<=h_addr1`, `p_wdata<=h_wdata`. `pend<=valid`, `pendw<=writereg` (back-to-back transfer accepted during the write data phase).
- `READ` → `RENABLE`. `WRITE` → `WENABLE`.
- `WENABLE` with `pend`=1: `pendw`=0 → `READ`, `pendw`=1 → `WRITE`. In both cases `p_addr<=h_addr1`, `p_wdata<=h_wdata` (write only); clear `pend`.
- `p_sel` is registered at entry to `READ`/`WRITE`, decoded from the address being loaded into `p_addr`:
  - 0x8000_0000–0x83FF_FFFF → 001
  - 0x8400_0000–0x87FF_FFFF → 010
  - 0x8800_0000–0x8BFF_FFFF → 100
  - other → 000; the APB phases still run and read data is whatever `p_rdata` carries.
- `p_write` is 1 in `WRITE`/`WENABLE`. `p_enable` is 1 in `RENABLE`/`WENABLE`. `p_sel` is held through setup and enable, and cleared on return to `IDLE`.
- `h_readyout` is combinational: 1 in `IDLE`, `WWAIT`, `RENABLE`, and `WENABLE` with `pend`=0; otherwise 0.

## Timing
- Reset values: state `IDLE`; `pend`, `pendw`, `p_sel`, `p_enable`, `p_write`, `p_addr`, `p_wdata` all 0; `h_readyout` 1; `h_resp` 0.
- Reset asserted mid-access drops `p_sel`/`p_enable` immediately (asynchronous) and discards any pending transfer.
- Read latency:
  - `valid` sampled at edge 0.
  - Setup phase from edge 1: `h_readyout`=0.
  - Enable phase from edge 2: `h_readyout`=1, `h_rdata` valid in that cycle.
- Write latency:
  - `valid` sampled at edge 0.
  - `WWAIT` from edge 1: data phase, `h_readyout`=1.
  - Setup from edge 2; enable from edge 3.
- Back-to-back reads run at 2 cycles per transfer with no `IDLE` between them.

## Configuration
- `APB_PREADY_EN` defined:
  - `p_ready` port exists.
  - `RENABLE`/`WENABLE` hold while `p_ready`=0: all APB outputs stable, `h_readyout`=0.
  - Transitions out of an enable state happen only on `p_ready`=1.
- `APB_PREADY_EN` undefined: no `p_ready` port; every access phase lasts exactly one cycle.

## Structure
- Shared bridge package holds:
  - the state enum;
  - the peripheral region base/limit constants (0x8000_0000, 0x8400_0000, 0x8800_0000, 0x8C00_0000);
  - the OKAY response constant.
- One sub-module, `apb_sel_decode`: combinational 32-bit address → 3-bit one-hot select, shared with any other bridge stage needing the decode.

## Test plan
- Single read of 0x8000_0010, `p_rdata`=0xDEAD_BEEF → `p_sel`=001 setup cycle, `p_enable`=1 next cycle, `h_rdata`=0xDEAD_BEEF with `h_readyout`=1 in that cycle.
- Single write 0x8400_0004 with data 0x1234_5678 → one `WWAIT` cycle, then `p_sel`=010, `p_write`=1, `p_wdata`=0x1234_5678 for setup+enable.
- Write 0x8800_0000 immediately followed by read 0x8000_0020 → read latched as pending; `h_readyout`=0 in `WENABLE`; read setup follows directly with `p_addr`=0x8000_0020.
- Two back-to-back reads → `READ`/`RENABLE`/`READ`/`RENABLE` with no `IDLE` between.
- Reset pulsed during `WRITE` → `p_sel`=0, `p_enable`=0, `h_readyout`=1 asynchronously; next `valid` starts cleanly from `IDLE`.
- With `APB_PREADY_EN`, `p_ready` low 3 cycles in `RENABLE` → outputs frozen and `h_readyout`=0 for 3 cycles, completion on the 4th.

Source files
------------

// File: rtl/apb_fsm_controller_pkg.sv
// Shared AHB-to-APB bridge definitions: sequencer states, peripheral address map
// and the AHB response encoding.
package apb_fsm_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RENABLE,
        WWAIT,
        WRITE,
        WENABLE
    } apb_state_t;

    localparam int NUM_PSEL = 3;

    // Region gi spans [REGION_BOUND[gi], REGION_BOUND[gi+1]); the last entry is the map limit.
    localparam logic [NUM_PSEL:0][31:0] REGION_BOUND = {
        32'h8C00_0000,
        32'h8800_0000,
        32'h8400_0000,
        32'h8000_0000
    };

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/apb_sel_decode.sv
// Combinational address decoder: 32-bit address to one-hot APB peripheral select.
// Addresses outside every region decode to all zeros.
module apb_sel_decode
    import apb_fsm_controller_pkg::*;
(
    input  logic [31:0]         addr,
    output logic [NUM_PSEL-1:0] sel
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PSEL; gi++) begin : g_region
            assign sel[gi] = (addr >= REGION_BOUND[gi]) && (addr < REGION_BOUND[gi+1]);
        end
    endgenerate

endmodule

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge; stalls the AHB pipeline while an APB
// access is in flight. Optional APB_PREADY_EN adds p_ready wait states in the enable phase.
module apb_fsm_controller
    import apb_fsm_controller_pkg::*;
(
    input  logic                h_clk,
    input  logic                h_reset,
    input  logic                valid,
    input  logic                writereg,
    input  logic [31:0]         h_addr,
    input  logic [31:0]         h_addr1,
    input  logic [31:0]         h_wdata,
    input  logic [31:0]         p_rdata,
`ifdef APB_PREADY_EN
    input  logic                p_ready,
`endif
    output logic                h_readyout,
    output logic [31:0]         h_rdata,
    output logic [1:0]          h_resp,
    output logic [NUM_PSEL-1:0] p_sel,
    output logic                p_enable,
    output logic                p_write,
    output logic [31:0]         p_addr,
    output logic [31:0]         p_wdata
);

    apb_state_t          state_reg, state_next;
    logic                pend_reg, pend_next;
    logic                pendw_reg, pendw_next;
    logic [NUM_PSEL-1:0] p_sel_reg, p_sel_next;
    logic [NUM_PSEL-1:0] sel_decoded;
    logic [31:0]         p_addr_reg, p_addr_next;
    logic [31:0]         p_wdata_reg, p_wdata_next;
    logic                access_done;
    logic                issue;
    logic                sel_load;

`ifdef APB_PREADY_EN
    assign access_done = p_ready;
`else
    assign access_done = 1'b1;
`endif

    // The select always follows the address being loaded into p_addr in the same cycle.
    apb_sel_decode u_sel_decode (
        .addr (p_addr_next),
        .sel  (sel_decoded)
    );

    always_comb begin
        state_next   = state_reg;
        pend_next    = pend_reg;
        pendw_next   = pendw_reg;
        p_addr_next  = p_addr_reg;
        p_wdata_next = p_wdata_reg;
        p_sel_next   = p_sel_reg;
        h_readyout   = 1'b0;
        issue        = 1'b0;
        sel_load     = 1'b0;

        case (state_reg)
            IDLE: begin
                h_readyout = 1'b1;
                issue      = 1'b1;
            end
            READ: begin
                state_next = RENABLE;
            end
            RENABLE: begin
                h_readyout = access_done;
                issue      = access_done;
            end
            WWAIT: begin
                // Write data phase: a following transfer may be accepted here and parked.
                h_readyout   = 1'b1;
                state_next   = WRITE;
                p_addr_next  = h_addr1;
                p_wdata_next = h_wdata;
                pend_next    = valid;
                pendw_next   = writereg;
                sel_load     = 1'b1;
            end
            WRITE: begin
                state_next = WENABLE;
            end
            WENABLE: begin
                if (pend_reg) begin
                    if (access_done) begin
                        pend_next   = 1'b0;
                        p_addr_next = h_addr1;
                        sel_load    = 1'b1;
                        if (pendw_reg) begin
                            state_next   = WRITE;
                            p_wdata_next = h_wdata;
                        end else begin
                            state_next = READ;
                        end
                    end
                end else begin
                    h_readyout = access_done;
                    issue      = access_done;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (issue) begin
            if (valid && !writereg) begin
                state_next  = READ;
                p_addr_next = h_addr;
                sel_load    = 1'b1;
            end else if (valid) begin
                state_next = WWAIT;
            end else begin
                state_next = IDLE;
            end
        end

        if (sel_load) begin
            p_sel_next = sel_decoded;
        end
        // WWAIT also drops the select so no peripheral sees a stale setup phase.
        if (state_next == IDLE || state_next == WWAIT) begin
            p_sel_next = '0;
        end
    end

    always_ff @(posedge h_clk or negedge h_reset) begin
        if (!h_reset) begin
            state_reg   <= IDLE;
            pend_reg    <= 1'b0;
            pendw_reg   <= 1'b0;
            p_sel_reg   <= '0;
            p_addr_reg  <= '0;
            p_wdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pend_reg    <= pend_next;
            pendw_reg   <= pendw_next;
            p_sel_reg   <= p_sel_next;
            p_addr_reg  <= p_addr_next;
            p_wdata_reg <= p_wdata_next;
        end
    end

    assign p_sel    = p_sel_reg;
    assign p_addr   = p_addr_reg;
    assign p_wdata  = p_wdata_reg;
    assign p_enable = (state_reg == RENABLE) || (state_reg == WENABLE);
    assign p_write  = (state_reg == WRITE) || (state_reg == WENABLE);
    assign h_rdata  = p_rdata;
    assign h_resp   = RESP_OKAY;

endmodule
